usb_audio_sample_fifo: RTL
==========================

Name: usb_audio_sample_fifo

Overview:
- Upstream stage of the audio top wrapper's USB path. Absorbs bursty stereo 24-bit samples from the USB audio endpoint logic.
- Re-times the samples to a steady per-frame cadence and drives usb_audio_left/right/valid into the top, which feeds the USB-to-I2S generator.
- Provides priming, underflow/overflow handling and a fill-level readout for rate-feedback firmware.

Parameters:
DEPTH, 16, FIFO depth in stereo sample pairs; power of two, >=4
ADDR_W, 4, log2(DEPTH)
PRIME_LEVEL, 8, fill level (pairs) required before streaming starts/resumes; 1..DEPTH

Ports:
clk_ref_external  input  1  sole clock; all logic rising-edge
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  block enable; low = flush and idle
in_left  input  24  incoming left sample
in_right  input  24  incoming right sample
in_valid  input  1  incoming pair valid
in_ready  output  1  block can accept pair this cycle
frame_div  input  16  clk cycles per output sample frame
clr_status  input  1  clears sticky underflow/overflow
out_left  output  24  to top usb_audio_left
out_right  output  24  to top usb_audio_right
out_valid  output  1  one-cycle pulse per emitted frame, to top usb_audio_valid
fill_level  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH
streaming  output  1  high while state RUN
underflow  output  1  sticky: FIFO empty at a RUN frame tick
overflow  output  1  sticky: pair dropped because FIFO full

Behaviour:
- Reset: all outputs 0. Pointers, fill, frame counter and flags cleared. State IDLE.
- Storage: DEPTH x 48-bit circular buffer. Write/read pointers are ADDR_W bits and wrap modulo DEPTH. fill_level is a separate counter of ADDR_W+1 bits.
- in_ready = enable && (fill_level != DEPTH). Combinational from registered state.
- Write:
  - A write occurs when in_valid && in_ready: store {in_left,in_right} at wr_ptr, increment wr_ptr.
  - in_valid && enable && full: pair dropped, overflow<=1.
- Frame counter:
  - Active only while enable; counts 0..N-1 with N = max(frame_div, 2).
  - tick is asserted in the cycle count==N-1, then count returns to 0.
  - A frame_div change takes effect at the next wrap.
  - enable low forces count=0.
- States:
  - IDLE: entered whenever enable=0 (any state, same cycle). Pointers and fill reset to 0 (flush), outputs zeroed, out_valid=0. Flags retained. enable=1 -> PRIME.
  - PRIME: out_valid stays 0. Ticks are ignored. When fill_level >= PRIME_LEVEL, go to RUN next cycle.
  - RUN, tick with fill>0: pop head, increment rd_ptr. Next cycle out_left/out_right = popped pair and out_valid=1 for exactly one cycle. Tick-to-valid latency = 1 cycle.
  - RUN, tick with fill==0: next cycle out_left=out_right=0, out_valid=1 (keeps downstream cadence), underflow<=1. State -> PRIME.
- Outputs hold their last value between pulses.
- Simultaneous write and pop in the same cycle: fill unchanged and both pointers advance. Full-check uses pre-cycle fill, so no write when full even if a pop occurs.
- Pop and write on the same empty slot cannot occur; a pop requires fill>0 at cycle start.
- clr_status: clears underflow/overflow next cycle. If a set condition occurs in the same cycle, set wins.
- streaming = (state==RUN), registered.
- Reset asserted mid-operation: immediate return to reset values. The FIFO contents are lost.

Test Plan:
- Reset/idle: rst_n low 5 cycles with in_valid=1 -> all outputs 0, in_ready=0 until enable=1 then in_ready=1, fill_level=0.
- Prime and stream: enable=1, frame_div=4, write 8 pairs L=i, R=0x800000+i (i=1..8) back-to-back -> streaming rises the cycle after fill=8; out_valid pulses every 4 cycles with L=1,2,3..., each 1 cycle after tick.
- Overflow: frame_div=1000, write 20 pairs in a burst -> first 16 accepted, in_ready=0 at fill=16, overflow=1; clr_status with in_valid low -> overflow=0.
- Underflow: 8 pairs primed, frame_div=4, no further writes -> 8 valid pulses with data, 9th pulse L=R=0 with underflow=1, streaming=0. Then 8 more writes -> streaming resumes.
- Concurrent read/write at full: fill=16 in RUN, in_valid held high on the tick -> pop occurs, write blocked that cycle (overflow=1), next cycle in_ready=1 and write accepted, fill back to 16.
- Enable drop mid-stream: enable=0 with fill=5 -> next cycle fill=0, out_valid=0, streaming=0, flags unchanged; re-enable starts in PRIME.

Source files
------------

// File: rtl/usb_audio_sample_fifo.sv
// Stereo 24-bit sample FIFO that absorbs bursty USB endpoint writes and
// replays them at a steady frame cadence towards the USB-to-I2S generator.
module usb_audio_sample_fifo #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int PRIME_LEVEL = 8
) (
  input  logic              clk_ref_external,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [23:0]       in_left,
  input  logic [23:0]       in_right,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       frame_div,
  input  logic              clr_status,
  output logic [23:0]       out_left,
  output logic [23:0]       out_right,
  output logic              out_valid,
  output logic [ADDR_W:0]   fill_level,
  output logic              streaming,
  output logic              underflow,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN
  } state_t;

  localparam logic [ADDR_W:0] FULL_LVL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PRIME_LVL = (ADDR_W + 1)'(PRIME_LEVEL);
  localparam logic [ADDR_W:0] FILL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [47:0]         mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     fill_q;
  logic [15:0]         frame_cnt, frame_len, frame_len_in;
  logic                tick, full;
  logic                do_write, do_drop, do_pop, do_under;

  assign full       = (fill_q == FULL_LVL);
  assign in_ready   = enable && !full;
  assign fill_level = fill_q;

  // Frame period is sampled only at a wrap so a mid-frame change never
  // produces a short or runt frame.
  assign frame_len_in = (frame_div < 16'd2) ? 16'd2 : frame_div;
  assign tick         = enable && (frame_cnt == frame_len - 16'd1);

  always_ff @(posedge clk_ref_external or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      frame_len <= 16'd2;
    end else if (!enable || tick) begin
      frame_cnt <= '0;
      frame_len <= frame_len_in;
    end else begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of the order the blocks evaluate.
  always_ff @(posedge clk_ref_external or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_PRIME;
        S_PRIME: if (fill_q >= PRIME_LVL) state_d = S_RUN;
        S_RUN:   if (tick && fill_q == '0) state_d = S_PRIME;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    do_write = in_valid && in_ready;
    do_drop  = in_valid && enable && full;
    do_pop   = (state_q == S_RUN) && tick && (fill_q != '0);
    do_under = (state_q == S_RUN) && tick && (fill_q == '0);
  end

  // NOTE: the sample store has no reset; a flush only moves the pointers,
  // and stale entries are never read because fill gates every pop.
  always_ff @(posedge clk_ref_external) begin
    if (do_write) mem[wr_ptr] <= {in_left, in_right};
  end

  always_ff @(posedge clk_ref_external or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_q    <= '0;
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      streaming <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      streaming <= (state_d == S_RUN);

      if (do_under)        underflow <= 1'b1;
      else if (clr_status) underflow <= 1'b0;
      if (do_drop)         overflow  <= 1'b1;
      else if (clr_status) overflow  <= 1'b0;

      if (!enable) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        fill_q    <= '0;
        out_left  <= '0;
        out_right <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= do_pop || do_under;
        if (do_pop) begin
          {out_left, out_right} <= mem[rd_ptr];
          rd_ptr <= rd_ptr + PTR_ONE;
        end else if (do_under) begin
          out_left  <= '0;
          out_right <= '0;
        end
        if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
        case ({do_write, do_pop})
          2'b10:   fill_q <= fill_q + FILL_ONE;
          2'b01:   fill_q <= fill_q - FILL_ONE;
          default: fill_q <= fill_q;
        endcase
      end
    end
  end

endmodule
